// File: rtl/dc_mem_responder.sv
// Memory-side responder for the data cache: services line misses (with optional
// dirty-victim writeback) over a 32-bit beat memory port, and single-word IO accesses.
module dc_mem_responder #(
  parameter int PA_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dc_miss,
  input  logic [31:0]       dc_miss_addr,
  input  logic              dc_evict,
  input  logic [31:0]       dc_evict_addr,
  input  logic [127:0]      dc_evict_data,
  output logic [127:0]      dc_data_fill,
  output logic              dc_miss_ack,
  input  logic              io_access,
  input  logic              io_rw,
  input  logic [31:0]       io_addr,
  input  logic [31:0]       io_wr_data,
  output logic [31:0]       io_rd_data,
  output logic              io_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [PA_W-1:0]   mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              iod_req,
  output logic              iod_we,
  output logic [31:0]       iod_addr,
  output logic [31:0]       iod_wdata,
  input  logic [31:0]       iod_rdata,
  input  logic              iod_ack,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVICT = 3'd1,
    S_FILL  = 3'd2,
    S_MACK  = 3'd3,
    S_IOREQ = 3'd4,
    S_IOACK = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t           state, state_next;
  logic [1:0]       beat;
  logic [PA_W-5:0]  miss_line;
  logic [PA_W-5:0]  evict_line;
  logic [127:0]     evict_buf;
  logic [95:0]      fill_buf;
  logic             io_rw_q;
  logic [31:0]      io_addr_q;
  logic [31:0]      io_wdata_q;

  // Valid/ready: mem_req/iod_req stay asserted with stable fields until the
  // corresponding ack is sampled high on a rising edge; each ack completes one beat.
  wire accept_io   = (state == S_IDLE) && io_access;
  wire accept_miss = (state == S_IDLE) && !io_access && dc_miss;
  wire last_beat   = mem_ack && (beat == 2'd3);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{dc_miss_addr[31:PA_W], dc_miss_addr[3:0],
                              dc_evict_addr[31:PA_W], dc_evict_addr[3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (io_access)    state_next = S_IOREQ;
        else if (dc_miss) state_next = dc_evict ? S_EVICT : S_FILL;
      end
      S_EVICT: if (last_beat) state_next = S_FILL;
      S_FILL:  if (last_beat) state_next = S_MACK;
      S_MACK:  state_next = S_GAP;
      S_IOREQ: if (iod_ack) state_next = S_IOACK;
      S_IOACK: state_next = S_GAP;
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    iod_req   = 1'b0;
    iod_we    = 1'b0;
    iod_addr  = '0;
    iod_wdata = '0;
    if (state == S_EVICT) begin
      mem_req  = 1'b1;
      mem_we   = 1'b1;
      mem_addr = {evict_line, beat, 2'b00};
      case (beat)
        2'd0:    mem_wdata = evict_buf[31:0];
        2'd1:    mem_wdata = evict_buf[63:32];
        2'd2:    mem_wdata = evict_buf[95:64];
        default: mem_wdata = evict_buf[127:96];
      endcase
    end else if (state == S_FILL) begin
      mem_req  = 1'b1;
      mem_addr = {miss_line, beat, 2'b00};
    end else if (state == S_IOREQ) begin
      iod_req   = 1'b1;
      iod_we    = io_rw_q;
      iod_addr  = io_addr_q;
      iod_wdata = io_wdata_q;
    end
  end

  assign dc_miss_ack = (state == S_MACK);
  assign io_ack      = (state == S_IOACK);
  assign fsm_state   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat         <= '0;
      miss_line    <= '0;
      evict_line   <= '0;
      evict_buf    <= '0;
      fill_buf     <= '0;
      io_rw_q      <= 1'b0;
      io_addr_q    <= '0;
      io_wdata_q   <= '0;
      dc_data_fill <= '0;
      io_rd_data   <= '0;
    end else begin
      if (accept_io) begin
        io_rw_q    <= io_rw;
        io_addr_q  <= io_addr;
        io_wdata_q <= io_wr_data;
      end
      if (accept_miss) begin
        miss_line  <= dc_miss_addr[PA_W-1:4];
        evict_line <= dc_evict_addr[PA_W-1:4];
        evict_buf  <= dc_evict_data;
        beat       <= '0;
      end
      // The 2-bit counter wraps to 0 on the final beat, ready for the fill phase.
      if ((state == S_EVICT || state == S_FILL) && mem_ack) beat <= beat + 2'd1;
      if (state == S_FILL && mem_ack) begin
        case (beat)
          2'd0:    fill_buf[31:0]  <= mem_rdata;
          2'd1:    fill_buf[63:32] <= mem_rdata;
          2'd2:    fill_buf[95:64] <= mem_rdata;
          default: dc_data_fill    <= {mem_rdata, fill_buf};
        endcase
      end
      if (state == S_IOREQ && iod_ack && !io_rw_q) io_rd_data <= iod_rdata;
    end
  end

endmodule
